// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared encodings and constants for the pipelined decode stage.
package decode_stage_pkg;

  // Register file geometry
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  // Default destination for link-style writes
  localparam logic [REG_ADDR_W-1:0] DEFAULT_LINK_REG = 3'd7;

  // Immediate field length selector
  typedef enum logic [1:0] {
    IMM5     = 2'b00,
    IMM8     = 2'b01,
    IMM11    = 2'b10,
    IMM_ZERO = 2'b11
  } len_immed_e;

  // Destination register selector
  typedef enum logic [1:0] {
    WREG_7_5  = 2'b00,
    WREG_4_2  = 2'b01,
    WREG_10_8 = 2'b10,
    WREG_LINK = 2'b11
  } w_reg_cont_e;

endpackage

// File: rtl/decode_rf.sv
// decode_rf: 8-entry register file with synchronous clear and one write port.
// Optional feature macro: DECODE_STAGE_BYPASS_EN forwards a same-cycle write
// onto the combinational read ports.
module decode_rf
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Register storage: cleared on reset, written from writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[wb_reg] <= wb_data;
    end
  end

  // Combinational read ports, optionally forwarding the in-flight write.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
`ifdef DECODE_STAGE_BYPASS_EN
    if (wb_en && (wb_reg == rs1_addr)) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
    if (wb_en && (wb_reg == rs2_addr)) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
`endif
  end

endmodule

// File: rtl/decode_stage_piped.sv
// decode_stage_piped: pipelined decode stage with ID/EX register, load-use
// stall and flush. Optional feature macro: DECODE_STAGE_BYPASS_EN (register
// file write-through); without it a same-cycle write to a used source stalls.
module decode_stage_piped
  import decode_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [REG_ADDR_W-1:0] LINK_REG   = DEFAULT_LINK_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [15:0]           instruc,
  input  logic [DATA_WIDTH-1:0] seq_PC,
  input  logic [1:0]            w_reg_cont,
  input  logic                  ext_type,
  input  logic [1:0]            len_immed,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic                  mem_read,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_WIDTH-1:0] data_1,
  output logic [DATA_WIDTH-1:0] data_2,
  output logic [DATA_WIDTH-1:0] ext_out,
  output logic [DATA_WIDTH-1:0] seq_PC_out,
  output logic [REG_ADDR_W-1:0] w_reg_out,
  output logic                  mem_read_out
);

  // Sign- or zero-extend the selected immediate field.
  function automatic logic [DATA_WIDTH-1:0] extend_imm(input logic [15:0] ins,
                                                       input logic sx,
                                                       input logic [1:0] len);
    logic [DATA_WIDTH-1:0] r;
    case (len)
      IMM5:     r = {{(DATA_WIDTH-5){sx & ins[4]}}, ins[4:0]};
      IMM8:     r = {{(DATA_WIDTH-8){sx & ins[7]}}, ins[7:0]};
      IMM11:    r = {{(DATA_WIDTH-11){sx & ins[10]}}, ins[10:0]};
      IMM_ZERO: r = '0;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Pick the destination register field.
  function automatic logic [REG_ADDR_W-1:0] select_dest(input logic [15:0] ins,
                                                        input logic [1:0] sel);
    logic [REG_ADDR_W-1:0] r;
    case (sel)
      WREG_7_5:  r = ins[7:5];
      WREG_4_2:  r = ins[4:2];
      WREG_10_8: r = ins[10:8];
      WREG_LINK: r = LINK_REG;
      default:   r = LINK_REG;
    endcase
    return r;
  endfunction

  logic [REG_ADDR_W-1:0] rs1_s, rs2_s;
  logic [DATA_WIDTH-1:0] rs1_data_s, rs2_data_s;
  logic                  load_s, ld_use_s, hazard_s;
  logic                  unused_instr_s;

  logic                  ex_valid_q, ex_valid_d;
  logic [DATA_WIDTH-1:0] data_1_q, data_1_d, data_2_q, data_2_d;
  logic [DATA_WIDTH-1:0] ext_q, ext_d, pc_q, pc_d;
  logic [REG_ADDR_W-1:0] w_reg_q, w_reg_d;
  logic                  mem_read_q, mem_read_d;

  assign rs1_s = instruc[10:8];
  assign rs2_s = instruc[7:5];
  // Opcode bits are decoded upstream; only the operand fields matter here.
  assign unused_instr_s = ^instruc[15:11];

  decode_rf #(.DATA_WIDTH(DATA_WIDTH)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .rs1_addr (rs1_s),
    .rs2_addr (rs2_s),
    .rs1_data (rs1_data_s),
    .rs2_data (rs2_data_s)
  );

  assign load_s   = ex_ready || !ex_valid_q;
  assign ld_use_s = ex_valid_q && mem_read_q && id_valid &&
                    ((uses_rs1 && (w_reg_q == rs1_s)) || (uses_rs2 && (w_reg_q == rs2_s)));
`ifdef DECODE_STAGE_BYPASS_EN
  assign hazard_s = ld_use_s;
`else
  logic wb_conflict_s;
  // Without forwarding, a read of a register being written this cycle waits one cycle.
  assign wb_conflict_s = id_valid && wb_en &&
                         ((uses_rs1 && (wb_reg == rs1_s)) || (uses_rs2 && (wb_reg == rs2_s)));
  assign hazard_s = ld_use_s || wb_conflict_s;
`endif
  assign id_ready = flush || (load_s && !hazard_s);

  // ID/EX next state: flush beats bubble beats capture beats hold.
  always_comb begin
    ex_valid_d = ex_valid_q;
    data_1_d   = data_1_q;
    data_2_d   = data_2_q;
    ext_d      = ext_q;
    pc_d       = pc_q;
    w_reg_d    = w_reg_q;
    mem_read_d = mem_read_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (load_s && hazard_s) begin
      ex_valid_d = 1'b0;
    end else if (load_s) begin
      ex_valid_d = id_valid;
      data_1_d   = rs1_data_s;
      data_2_d   = rs2_data_s;
      ext_d      = extend_imm(instruc, ext_type, len_immed);
      pc_d       = seq_PC;
      w_reg_d    = select_dest(instruc, w_reg_cont);
      mem_read_d = mem_read;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // ID/EX pipeline register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      data_1_q   <= '0;
      data_2_q   <= '0;
      ext_q      <= '0;
      pc_q       <= '0;
      w_reg_q    <= '0;
      mem_read_q <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      data_1_q   <= data_1_d;
      data_2_q   <= data_2_d;
      ext_q      <= ext_d;
      pc_q       <= pc_d;
      w_reg_q    <= w_reg_d;
      mem_read_q <= mem_read_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign data_1       = data_1_q;
  assign data_2       = data_2_q;
  assign ext_out      = ext_q;
  assign seq_PC_out   = pc_q;
  assign w_reg_out    = w_reg_q;
  assign mem_read_out = mem_read_q;

endmodule

// File: tb/tb_decode_stage_piped.sv
// Testbench for decode_stage_piped: directed scenarios plus random traffic,
// checked through a scoreboard queue fed by a behavioural model.
module tb_decode_stage_piped;

  typedef struct {
    logic        rst, flush, id_valid;
    logic [15:0] instruc, seq_pc;
    logic [1:0]  w_reg_cont;
    logic        ext_type;
    logic [1:0]  len_immed;
    logic        uses_rs1, uses_rs2, mem_read, wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        ex_ready;
  } stim_t;

  typedef struct {
    logic [15:0] d1, d2, ext, pc;
    logic [2:0]  wreg;
    logic        mr;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, id_valid = 1'b0, ex_ready = 1'b1;
  logic [15:0] instruc = 16'h0000, seq_PC = 16'h0000, wb_data = 16'h0000;
  logic [1:0]  w_reg_cont = 2'b00, len_immed = 2'b00;
  logic        ext_type = 1'b0, uses_rs1 = 1'b0, uses_rs2 = 1'b0, mem_read = 1'b0, wb_en = 1'b0;
  logic [2:0]  wb_reg = 3'd0;
  logic        id_ready, ex_valid, mem_read_out;
  logic [15:0] data_1, data_2, ext_out, seq_PC_out;
  logic [2:0]  w_reg_out;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;
  rec_t sb_q[$];
  logic [15:0] rf_m [8];

  decode_stage_piped dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .instruc(instruc), .seq_PC(seq_PC), .w_reg_cont(w_reg_cont),
    .ext_type(ext_type), .len_immed(len_immed), .uses_rs1(uses_rs1),
    .uses_rs2(uses_rs2), .mem_read(mem_read), .flush(flush),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .data_1(data_1),
    .data_2(data_2), .ext_out(ext_out), .seq_PC_out(seq_PC_out),
    .w_reg_out(w_reg_out), .mem_read_out(mem_read_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Immediate value from field length and extension rule, by plain arithmetic.
  function automatic logic [15:0] model_ext(input logic [15:0] ins, input logic sx, input logic [1:0] len);
    int bits;
    int v;
    case (len)
      2'b00:   bits = 5;
      2'b01:   bits = 8;
      2'b10:   bits = 11;
      default: bits = 0;
    endcase
    if (bits == 0) return 16'h0000;
    v = int'(ins) % (1 << bits);
    if (sx && (v >= (1 << (bits - 1)))) v = v - (1 << bits);
    return v[15:0];
  endfunction

  function automatic logic [2:0] model_dest(input logic [15:0] ins, input logic [1:0] sel);
    int v;
    case (sel)
      2'b00:   v = (int'(ins) >> 5) % 8;
      2'b01:   v = (int'(ins) >> 2) % 8;
      2'b10:   v = (int'(ins) >> 8) % 8;
      default: v = 7;
    endcase
    return v[2:0];
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.flush = 1'b0; s.id_valid = 1'b0; s.instruc = 16'h0000;
    s.seq_pc = 16'h0000; s.w_reg_cont = 2'b00; s.ext_type = 1'b0; s.len_immed = 2'b00;
    s.uses_rs1 = 1'b0; s.uses_rs2 = 1'b0; s.mem_read = 1'b0; s.wb_en = 1'b0;
    s.wb_reg = 3'd0; s.wb_data = 16'h0000; s.ex_ready = 1'b1;
    return s;
  endfunction

  function automatic stim_t instr(input logic [15:0] ins, input logic u1, input logic u2, input logic mr);
    stim_t s = idle();
    s.id_valid = 1'b1; s.instruc = ins; s.uses_rs1 = u1; s.uses_rs2 = u2; s.mem_read = mr;
    s.seq_pc = 16'($urandom);
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst = ($urandom_range(0, 199) == 0); s.flush = ($urandom_range(0, 15) == 0);
    s.id_valid = ($urandom_range(0, 3) != 0); s.instruc = 16'($urandom);
    s.seq_pc = 16'($urandom); s.w_reg_cont = 2'($urandom); s.ext_type = 1'($urandom);
    s.len_immed = 2'($urandom); s.uses_rs1 = 1'($urandom); s.uses_rs2 = 1'($urandom);
    s.mem_read = 1'($urandom); s.wb_en = ($urandom_range(0, 2) == 0);
    s.wb_reg = 3'($urandom); s.wb_data = 16'($urandom);
    s.ex_ready = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  // One clock cycle: drive, predict acceptance, check id_ready, update the model.
  task automatic step(input stim_t s);
    logic exv, ld, hz, exp_ready;
    logic [2:0] rs1, rs2;
    rec_t r;
    @(posedge clk); #1;
    rst = s.rst; flush = s.flush; id_valid = s.id_valid; instruc = s.instruc;
    seq_PC = s.seq_pc; w_reg_cont = s.w_reg_cont; ext_type = s.ext_type;
    len_immed = s.len_immed; uses_rs1 = s.uses_rs1; uses_rs2 = s.uses_rs2;
    mem_read = s.mem_read; wb_en = s.wb_en; wb_reg = s.wb_reg; wb_data = s.wb_data;
    ex_ready = s.ex_ready;
    rs1 = s.instruc[10:8];
    rs2 = s.instruc[7:5];
    exv = (sb_q.size() > 0);
    ld  = s.ex_ready || !exv;
    hz  = 1'b0;
    if (exv) hz = sb_q[0].mr && s.id_valid &&
                  ((s.uses_rs1 && sb_q[0].wreg == rs1) || (s.uses_rs2 && sb_q[0].wreg == rs2));
`ifndef DECODE_STAGE_BYPASS_EN
    hz = hz || (s.id_valid && s.wb_en &&
                ((s.uses_rs1 && s.wb_reg == rs1) || (s.uses_rs2 && s.wb_reg == rs2)));
`endif
    exp_ready = s.flush || (ld && !hz);
    r.d1 = rf_m[rs1];
    r.d2 = rf_m[rs2];
`ifdef DECODE_STAGE_BYPASS_EN
    if (s.wb_en && s.wb_reg == rs1) r.d1 = s.wb_data;
    if (s.wb_en && s.wb_reg == rs2) r.d2 = s.wb_data;
`endif
    r.ext  = model_ext(s.instruc, s.ext_type, s.len_immed);
    r.pc   = s.seq_pc;
    r.wreg = model_dest(s.instruc, s.w_reg_cont);
    r.mr   = s.mem_read;
    @(negedge clk);
    if (mon_en) check("id_ready", 80'(id_ready), 80'(exp_ready));
    #1;
    if (s.rst) begin
      sb_q.delete();
      for (int i = 0; i < 8; i++) rf_m[i] = 16'h0000;
    end else begin
      if (s.flush) begin
        if (exv && !s.ex_ready) void'(sb_q.pop_back());
      end else if (ld && !hz && s.id_valid) begin
        sb_q.push_back(r);
      end
      if (s.wb_en) rf_m[s.wb_reg] = s.wb_data;
    end
  endtask

  // Monitor: compare the EX side against the scoreboard head every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("ex_valid", 80'(ex_valid), 80'(sb_q.size() > 0));
        if (ex_valid === 1'b1 && sb_q.size() > 0) begin
          check("ex_fields",
                80'({data_1, data_2, ext_out, seq_PC_out, w_reg_out, mem_read_out}),
                80'({sb_q[0].d1, sb_q[0].d2, sb_q[0].ext, sb_q[0].pc, sb_q[0].wreg, sb_q[0].mr}));
          if (ex_ready === 1'b1) void'(sb_q.pop_front());
        end
      end
    end
  end

  // Stimulus: directed scenarios, random traffic, drain, summary.
  initial begin
    stim_t s;
    s = idle(); s.rst = 1'b1;
    step(s);
    mon_en = 1'b1;
    step(s);
    step(idle());
    check("rst_ex_valid", 80'(ex_valid), 80'(1'b0));
    check("rst_outputs", 80'({data_1, data_2, ext_out, seq_PC_out, w_reg_out, mem_read_out}), 80'(0));

    // Write r3, then read it through rs1
    s = idle(); s.wb_en = 1'b1; s.wb_reg = 3'd3; s.wb_data = 16'h1234;
    step(s);
    step(instr(16'h0300, 1'b1, 1'b0, 1'b0));
    step(idle());
    check("tp_rs1_read", 80'(data_1), 80'(16'h1234));

    // Load to r2 followed by a dependent instruction: one bubble
    s = instr(16'h0200, 1'b0, 1'b0, 1'b1); s.w_reg_cont = 2'b10;
    step(s);
    s = instr(16'h0200, 1'b1, 1'b0, 1'b0);
    step(s);
    step(s);
    step(idle());

    // EX back-pressure for three cycles
    step(instr(16'h0455, 1'b1, 1'b1, 1'b0));
    s = instr(16'h0123, 1'b0, 1'b0, 1'b0); s.ex_ready = 1'b0;
    repeat (3) step(s);
    s.ex_ready = 1'b1;
    step(s);
    step(idle());

    // Flush while EX and ID both hold instructions
    s = instr(16'h0666, 1'b0, 1'b0, 1'b1); s.w_reg_cont = 2'b10;
    step(s);
    s = instr(16'h0600, 1'b1, 1'b0, 1'b0); s.flush = 1'b1; s.ex_ready = 1'b0;
    step(s);
    step(idle());

    // Immediate forms and link destination
    s = instr(16'h0010, 1'b0, 1'b0, 1'b0); s.len_immed = 2'b00; s.ext_type = 1'b1;
    step(s);
    s = instr(16'h07FF, 1'b0, 1'b0, 1'b0); s.len_immed = 2'b10; s.ext_type = 1'b0;
    s.w_reg_cont = 2'b11;
    step(s);
    check("tp_imm5_sext", 80'(ext_out), 80'(16'hFFF0));
    step(idle());
    check("tp_imm11_zext", 80'(ext_out), 80'(16'h07FF));
    check("tp_link_dest", 80'(w_reg_out), 80'(3'd7));

    // Same-cycle writeback to r1 read through rs2
    s = instr(16'h0020, 1'b0, 1'b1, 1'b0);
    s.wb_en = 1'b1; s.wb_reg = 3'd1; s.wb_data = 16'hBEEF;
    step(s);
`ifndef DECODE_STAGE_BYPASS_EN
    s.wb_en = 1'b0;
    step(s);
`endif
    step(idle());
    check("tp_wb_rs2", 80'(data_2), 80'(16'hBEEF));

    // Reset in the middle of a stall
    step(instr(16'h0111, 1'b0, 1'b0, 1'b0));
    s = instr(16'h0222, 1'b0, 1'b0, 1'b0); s.ex_ready = 1'b0;
    step(s);
    s.rst = 1'b1;
    step(s);
    step(idle());

    for (int n = 0; n < 3000; n++) step(rand_stim());
    repeat (3) step(idle());
    check("drain_empty", 80'(sb_q.size()), 80'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
